// File: rtl/ctrl_pkg.sv
// Shared decode types for the control pipe: RV32I opcodes, ALU codes,
// operand/writeback selects and the packed control word.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wbsel_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } rs2sel_e;

  typedef struct packed {
    logic    pcsel;
    logic    immsel;
    logic    regwren;
    logic    rs1sel;
    rs2sel_e rs2sel;
    logic    memren;
    logic    memwren;
    wbsel_e  wbsel;
    alu_op_e alusel;
    logic    illegal;
  } ctrl_t;

  // alt selects SUB for funct3=0 or SRA for funct3=5; caller qualifies it.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_dec.sv
// Purely combinational RV32I decoder: instruction word to control word,
// plus which source registers the instruction actually reads.
module control_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_fields;

  assign opcode        = insn[6:0];
  assign funct3        = insn[14:12];
  assign funct7_5      = insn[30];
  assign unused_fields = ^{insn[31], insn[29:15], insn[11:7]};

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.regwren = 1'b1;
        ctrl.alusel  = alu_from_funct3(funct3, funct7_5);
        uses_rs2     = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.immsel  = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        ctrl.alusel  = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7_5);
      end
      OPC_LOAD: begin
        ctrl.immsel  = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        ctrl.memren  = 1'b1;
        ctrl.wbsel   = WB_MEM;
      end
      OPC_STORE: begin
        ctrl.immsel  = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        ctrl.memwren = 1'b1;
        uses_rs2     = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.immsel = 1'b1;
        ctrl.pcsel  = 1'b1;
        uses_rs2    = 1'b1;
        case (funct3)
          3'd0, 3'd1: ctrl.alusel = ALU_SUB;
          3'd4, 3'd5: ctrl.alusel = ALU_SLT;
          3'd6, 3'd7: ctrl.alusel = ALU_SLTU;
          default:    ctrl.alusel = ALU_ADD;
        endcase
      end
      OPC_JAL: begin
        ctrl.immsel  = 1'b1;
        ctrl.pcsel   = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs1sel  = 1'b1;
        ctrl.wbsel   = WB_PC4;
        uses_rs1     = 1'b0;
      end
      OPC_JALR: begin
        ctrl.immsel  = 1'b1;
        ctrl.pcsel   = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        ctrl.wbsel   = WB_PC4;
      end
      OPC_LUI: begin
        ctrl.immsel  = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        uses_rs1     = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl.immsel  = 1'b1;
        ctrl.regwren = 1'b1;
        ctrl.rs1sel  = 1'b1;
        ctrl.rs2sel  = OP2_IMM;
        uses_rs1     = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Decode stage output register with valid/ready handshake, load-use
// interlock, flush, and saturating issue/bubble counters.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DWIDTH-1:0]    insn_i,
  input  logic [DWIDTH-1:0]    pc_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DWIDTH-1:0]    pc_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic                 pcsel_o,
  output logic                 immsel_o,
  output logic                 regwren_o,
  output logic                 rs1sel_o,
  output logic                 rs2sel_o,
  output logic                 memren_o,
  output logic                 memwren_o,
  output logic [1:0]           wbsel_o,
  output logic [3:0]           alusel_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] issue_cnt_o,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e                state_q, state_d;
  ctrl_t                 dec_ctrl, ctrl_q;
  logic                  uses_rs1, uses_rs2;
  logic                  hazard, xfer_in, load, count_issue, count_bubble;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, bubble_cnt_q;

  control_dec u_dec (
    .insn     (insn_i[31:0]),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign valid_o = (state_q == ST_FULL);

  // Load-use: the held load writes a register the incoming instruction reads.
  assign hazard = (HAZARD_EN != 0) && valid_i && valid_o && ctrl_q.memren && (rd_o != 5'd0)
                  && ((uses_rs1 && (insn_i[19:15] == rd_o)) || (uses_rs2 && (insn_i[24:20] == rd_o)));

  assign ready_o = ~reset & (~valid_o | ready_i) & ~hazard & ~flush_i;
  assign xfer_in = valid_i & ready_o;

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    count_issue  = 1'b0;
    count_bubble = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d = ST_FULL;
            load    = 1'b1;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            count_issue = 1'b1;
            if (xfer_in) begin
              load = 1'b1;
            end else begin
              state_d      = ST_EMPTY;
              count_bubble = hazard;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: the payload registers are reset too, because downstream observes
  // them even while valid_o is low and they must read as a clean zero word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      pc_o   <= '0;
      rd_o   <= '0;
      rs1_o  <= '0;
      rs2_o  <= '0;
    end else if (load) begin
      ctrl_q <= dec_ctrl;
      pc_o   <= pc_i;
      rd_o   <= insn_i[11:7];
      rs1_o  <= insn_i[19:15];
      rs2_o  <= insn_i[24:20];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (count_issue && (issue_cnt_q != '1))   issue_cnt_q  <= issue_cnt_q + 1'b1;
      if (count_bubble && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign pcsel_o      = ctrl_q.pcsel;
  assign immsel_o     = ctrl_q.immsel;
  assign regwren_o    = ctrl_q.regwren;
  assign rs1sel_o     = ctrl_q.rs1sel;
  assign rs2sel_o     = ctrl_q.rs2sel;
  assign memren_o     = ctrl_q.memren;
  assign memwren_o    = ctrl_q.memwren;
  assign wbsel_o      = ctrl_q.wbsel;
  assign alusel_o     = ctrl_q.alusel;
  assign illegal_o    = ctrl_q.illegal;
  assign issue_cnt_o  = issue_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: default instance plus a no-interlock and a
// 4-bit-counter instance sharing the same upstream/downstream stimulus.
module tb_control_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] insn_i, pc_i;
  logic        valid_i, flush_i, ready_i;

  logic        ready_o, valid_o, pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o;
  logic        memren_o, memwren_o, illegal_o;
  logic [31:0] pc_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [1:0]  wbsel_o;
  logic [3:0]  alusel_o;
  logic [15:0] issue_cnt_o, bubble_cnt_o;

  logic        nh_ready_o, nh_valid_o, nh_pcsel_o, nh_immsel_o, nh_regwren_o, nh_rs1sel_o;
  logic        nh_rs2sel_o, nh_memren_o, nh_memwren_o, nh_illegal_o;
  logic [31:0] nh_pc_o;
  logic [4:0]  nh_rd_o, nh_rs1_o, nh_rs2_o;
  logic [1:0]  nh_wbsel_o;
  logic [3:0]  nh_alusel_o;
  logic [15:0] nh_issue_cnt_o, nh_bubble_cnt_o;

  logic        c4_ready_o, c4_valid_o, c4_pcsel_o, c4_immsel_o, c4_regwren_o, c4_rs1sel_o;
  logic        c4_rs2sel_o, c4_memren_o, c4_memwren_o, c4_illegal_o;
  logic [31:0] c4_pc_o;
  logic [4:0]  c4_rd_o, c4_rs1_o, c4_rs2_o;
  logic [1:0]  c4_wbsel_o;
  logic [3:0]  c4_alusel_o;
  logic [3:0]  c4_issue_cnt_o, c4_bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_pipe u_dut (
    .clk(clk), .reset(reset), .insn_i(insn_i), .pc_i(pc_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .pcsel_o(pcsel_o),
    .immsel_o(immsel_o), .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
    .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o), .alusel_o(alusel_o),
    .illegal_o(illegal_o), .issue_cnt_o(issue_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  control_pipe #(.HAZARD_EN(0)) u_nohz (
    .clk(clk), .reset(reset), .insn_i(insn_i), .pc_i(pc_i), .valid_i(valid_i),
    .ready_o(nh_ready_o), .flush_i(flush_i), .valid_o(nh_valid_o), .ready_i(ready_i),
    .pc_o(nh_pc_o), .rd_o(nh_rd_o), .rs1_o(nh_rs1_o), .rs2_o(nh_rs2_o), .pcsel_o(nh_pcsel_o),
    .immsel_o(nh_immsel_o), .regwren_o(nh_regwren_o), .rs1sel_o(nh_rs1sel_o),
    .rs2sel_o(nh_rs2sel_o), .memren_o(nh_memren_o), .memwren_o(nh_memwren_o),
    .wbsel_o(nh_wbsel_o), .alusel_o(nh_alusel_o), .illegal_o(nh_illegal_o),
    .issue_cnt_o(nh_issue_cnt_o), .bubble_cnt_o(nh_bubble_cnt_o)
  );

  control_pipe #(.CNT_WIDTH(4)) u_cnt4 (
    .clk(clk), .reset(reset), .insn_i(insn_i), .pc_i(pc_i), .valid_i(valid_i),
    .ready_o(c4_ready_o), .flush_i(flush_i), .valid_o(c4_valid_o), .ready_i(ready_i),
    .pc_o(c4_pc_o), .rd_o(c4_rd_o), .rs1_o(c4_rs1_o), .rs2_o(c4_rs2_o), .pcsel_o(c4_pcsel_o),
    .immsel_o(c4_immsel_o), .regwren_o(c4_regwren_o), .rs1sel_o(c4_rs1sel_o),
    .rs2sel_o(c4_rs2sel_o), .memren_o(c4_memren_o), .memwren_o(c4_memwren_o),
    .wbsel_o(c4_wbsel_o), .alusel_o(c4_alusel_o), .illegal_o(c4_illegal_o),
    .issue_cnt_o(c4_issue_cnt_o), .bubble_cnt_o(c4_bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    insn_i = 32'h0; pc_i = 32'h0;
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_alusel", alusel_o, 0);
    check("rst_wbsel", wbsel_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_issue", issue_cnt_o, 0);
    check("rst_bubble", bubble_cnt_o, 0);
    reset = 1'b0;

    // add x3,x1,x2
    insn_i = 32'h002081B3; pc_i = 32'h100; valid_i = 1'b1;
    #1 check("add_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    check("add_valid", valid_o, 1);
    check("add_alusel", alusel_o, 0);
    check("add_regwren", regwren_o, 1);
    check("add_rs2sel", rs2sel_o, 0);
    check("add_wbsel", wbsel_o, 0);
    check("add_rd", rd_o, 3);
    check("add_rs1", rs1_o, 1);
    check("add_rs2", rs2_o, 2);
    check("add_pc", pc_o, 32'h100);
    check("add_illegal", illegal_o, 0);
    tick();
    check("add_out_valid", valid_o, 0);
    check("add_issue", issue_cnt_o, 1);

    // lw x5,0(x1) then dependent add x6,x5,x0
    insn_i = 32'h0000A283; pc_i = 32'h104; valid_i = 1'b1;
    tick();
    check("lw_memren", memren_o, 1);
    check("lw_wbsel", wbsel_o, 1);
    check("lw_rs2sel", rs2sel_o, 1);
    check("lw_rd", rd_o, 5);
    insn_i = 32'h00028333; pc_i = 32'h108;
    #1;
    check("luse_ready", ready_o, 0);
    check("luse_nh_ready", nh_ready_o, 1);
    tick();
    check("bubble_valid", valid_o, 0);
    check("bubble_cnt", bubble_cnt_o, 1);
    check("bubble_issue", issue_cnt_o, 2);
    check("bubble_ready", ready_o, 1);
    check("nh_valid", nh_valid_o, 1);
    check("nh_rd", nh_rd_o, 6);
    check("nh_bubble", nh_bubble_cnt_o, 0);
    tick();
    valid_i = 1'b0;
    check("luse_add_valid", valid_o, 1);
    check("luse_add_rd", rd_o, 6);
    check("luse_add_pc", pc_o, 32'h108);
    tick();
    check("luse_issue", issue_cnt_o, 3);
    check("c4_bubble", c4_bubble_cnt_o, 1);

    // sub x4,x1,x2 held under backpressure
    insn_i = 32'h40208233; pc_i = 32'h10C; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    insn_i = 32'h00000013; pc_i = 32'h110;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", valid_o, 1);
      check("hold_alusel", alusel_o, 1);
      check("hold_rd", rd_o, 4);
      check("hold_pc", pc_o, 32'h10C);
      check("hold_ready", ready_o, 0);
      check("hold_issue", issue_cnt_o, 3);
      tick();
    end

    // reset in the middle of backpressure
    reset = 1'b1; flush_i = 1'b1;
    #1 check("mid_rst_ready", ready_o, 0);
    tick();
    reset = 1'b0; flush_i = 1'b0;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_alusel", alusel_o, 0);
    check("mid_rst_regwren", regwren_o, 0);
    check("mid_rst_rd", rd_o, 0);
    check("mid_rst_pc", pc_o, 0);
    check("mid_rst_issue", issue_cnt_o, 0);
    check("mid_rst_bubble", bubble_cnt_o, 0);

    // flush while FULL drops the held add and the incoming beq
    insn_i = 32'h002081B3; pc_i = 32'h200; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    check("fl_full", valid_o, 1);
    insn_i = 32'h00208463; pc_i = 32'h204; flush_i = 1'b1;
    #1 check("fl_ready", ready_o, 0);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    check("fl_valid", valid_o, 0);
    check("fl_issue", issue_cnt_o, 0);
    check("fl_bubble", bubble_cnt_o, 0);
    tick();
    check("fl_valid2", valid_o, 0);

    // illegal, sw, jal, beq, then 20 back-to-back addi
    ready_i = 1'b1; valid_i = 1'b1;
    insn_i = 32'hFFFFFFFF; pc_i = 32'h300;
    tick();
    check("ill_illegal", illegal_o, 1);
    check("ill_regwren", regwren_o, 0);
    check("ill_memren", memren_o, 0);
    check("ill_memwren", memwren_o, 0);
    check("ill_alusel", alusel_o, 0);
    check("ill_valid", valid_o, 1);
    insn_i = 32'h0020A023; pc_i = 32'h304;
    tick();
    check("sw_memwren", memwren_o, 1);
    check("sw_regwren", regwren_o, 0);
    check("sw_rs2sel", rs2sel_o, 1);
    check("sw_illegal", illegal_o, 0);
    insn_i = 32'h008000EF; pc_i = 32'h308;
    tick();
    check("jal_pcsel", pcsel_o, 1);
    check("jal_rs1sel", rs1sel_o, 1);
    check("jal_wbsel", wbsel_o, 2);
    check("jal_regwren", regwren_o, 1);
    insn_i = 32'h00208463; pc_i = 32'h30C;
    tick();
    check("beq_alusel", alusel_o, 1);
    check("beq_pcsel", pcsel_o, 1);
    check("beq_regwren", regwren_o, 0);
    insn_i = 32'h00100093;
    for (int i = 0; i < 20; i++) begin
      pc_i = 32'h400 + 32'(i * 4);
      tick();
    end
    check("addi_rs2sel", rs2sel_o, 1);
    check("addi_pc", pc_o, 32'h44C);
    valid_i = 1'b0;
    tick();
    check("final_issue", issue_cnt_o, 24);
    check("final_bubble", bubble_cnt_o, 0);
    check("c4_issue_sat", c4_issue_cnt_o, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter DWIDTH, default 32: instruction and PC width.
REQ-002 Parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-003 Parameter HAZARD_EN, default 1: enables load-use interlock; when 0, no bubbles are ever inserted.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 insn_i  in  DWIDTH  raw RV32I instruction.
REQ-008 pc_i  in  DWIDTH  PC of insn_i.
REQ-009 valid_i  in  1  insn_i/pc_i valid.
REQ-010 ready_o  out  1  block accepts the upstream instruction this cycle.
REQ-011 flush_i  in  1  discard the held and incoming instruction.
REQ-012 valid_o  out  1  registered control word valid.
REQ-013 ready_i  in  1  downstream accepts the control word.
REQ-014 pc_o  out  DWIDTH  registered PC.
REQ-015 rd_o, rs1_o, rs2_o  out  5 each  registered register indices.
REQ-016 pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o  out  1 each  registered control bits.
REQ-017 wbsel_o  out  2  WB_ALU/WB_MEM/WB_PC4; alusel_o  out  4  ALU operation code.
REQ-018 illegal_o  out  1  unrecognised opcode.
REQ-019 issue_cnt_o, bubble_cnt_o  out  CNT_WIDTH  saturating counters.

Function
REQ-020 Decode SHALL follow the RV32I map: R-type uses funct3 and funct7[5] (SUB/SRA); I-arith uses funct7[5] only for funct3=5 (SRAI); loads/stores/JALR/LUI/AUIPC use ADD; BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
REQ-021 rs2sel: OP2_RS2 for R, B, JAL; OP2_IMM for I, load, S, JALR, U. wbsel: WB_MEM for loads; WB_PC4 for JAL/JALR; WB_ALU otherwise.
REQ-022 regwren=1 for R, I, load, JAL, JALR, LUI, AUIPC; memren=1 only for loads; memwren=1 only for stores; rs1sel selects PC for AUIPC and JAL; pcsel=1 for JAL/JALR/B-type.
REQ-023 Unknown opcode SHALL give illegal_o=1, every write/enable bit 0, alusel=ADD, rs2sel=OP2_RS2, wbsel=WB_ALU; it is still issued.
REQ-024 Decode-to-output latency SHALL be exactly one cycle.
REQ-025 A transfer in SHALL occur when valid_i & ready_o. A transfer out SHALL occur when valid_o & ready_i.
REQ-026 ready_o = (~valid_o | ready_i) & ~hazard & ~flush_i.
REQ-027 hazard = HAZARD_EN & valid_i & valid_o & memren_o & (rd_o!=0) & ((uses_rs1 & rs1==rd_o) | (uses_rs2 & rs2==rd_o)).
REQ-028 uses_rs1 is false for LUI, AUIPC and JAL; uses_rs2 is true only for R, S and B.
REQ-029 The output register SHALL behave as a state machine with two states:
- EMPTY (valid_o=0): transfer in goes to FULL.
- FULL, on ready_i: transfer in stays FULL with new contents; no transfer goes to EMPTY; hazard goes to EMPTY (bubble).
- FULL, without ready_i: hold all outputs stable.
REQ-030 flush_i SHALL take priority over all events: the next state is EMPTY, the incoming instruction is dropped, and no counter changes.
REQ-031 issue_cnt SHALL increment on every transfer out; bubble_cnt SHALL increment on every hazard-caused bubble. Both saturate at 2^CNT_WIDTH-1.
REQ-032 rd_o/rs1_o/rs2_o SHALL be the raw instruction fields regardless of format.

Reset
REQ-033 Reset SHALL force EMPTY: valid_o=0, every control output 0, alusel=ADD, wbsel=WB_ALU, pc_o=0, index outputs 0, illegal_o=0, both counters 0.
REQ-034 Reset asserted mid-operation SHALL discard the held instruction and override flush_i and ready_i.
REQ-035 ready_o SHALL be 0 while reset is high.

Structure
REQ-036 Package ctrl_pkg SHALL hold the opcode constants, alusel encodings, the wbsel and rs2sel encodings, and a packed ctrl_t struct.
REQ-037 Combinational decode SHALL live in one sub-module, control_dec (insn in, ctrl_t plus uses_rs1/uses_rs2 out). control_pipe adds the register, handshake, hazard logic and counters.

Verification
REQ-038 Issue 0x002081B3 (add x3,x1,x2) with ready_i=1 -> next cycle valid_o=1, alusel=ADD, regwren=1, rs2sel=OP2_RS2, wbsel=WB_ALU, rd_o=3, issue_cnt=1.
REQ-039 Issue 0x0000A283 (lw x5,0(x1)) then 0x00028333 (add x6,x5,x0) -> ready_o=0 for exactly one cycle, one EMPTY cycle, bubble_cnt=1, add issued next; repeat with HAZARD_EN=0 -> no bubble.
REQ-040 Hold 0x40208233 (sub) with ready_i=0 for 3 cycles -> outputs stable, alusel=SUB, ready_o=0, issue_cnt unchanged.
REQ-041 Assert flush_i with valid_i=1 and insn 0x00208463 (beq) while FULL -> next cycle valid_o=0, beq never issued, counters unchanged.
REQ-042 Issue 0xFFFFFFFF -> illegal_o=1, regwren=memwren=memren=0. With CNT_WIDTH=4, 20 back-to-back issues -> issue_cnt_o=15.
REQ-043 Assert reset during the backpressure sequence -> next cycle all outputs at their REQ-033 values.
